// File: rtl/aes_seq_ctrl_if.sv
// ============================================================================
// Module   : aes_seq_ctrl_if
// Brief    : Host command/response channels and aes_core strobe bus for the
//            AES command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic             cmd_keylen;
    logic [255:0]     cmd_key;
    logic [127:0]     cmd_block;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [127:0]     rsp_data;
    logic             rsp_err;

    logic             core_init;
    logic             core_next;
    logic             core_ready;
    logic             core_result_valid;
    logic [127:0]     core_result;
    logic [255:0]     core_key;
    logic             core_keylen;
    logic [127:0]     core_block;

    logic             trigger;
    logic             key_loaded;
    logic [CNT_W-1:0] enc_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_keylen, cmd_key, cmd_block,
        input  rsp_ready,
        input  core_ready, core_result_valid, core_result,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output core_init, core_next, core_key, core_keylen, core_block,
        output trigger, key_loaded, enc_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_keylen, cmd_key, cmd_block,
        output rsp_ready,
        output core_ready, core_result_valid, core_result,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  core_init, core_next, core_key, core_keylen, core_block,
        input  trigger, key_loaded, enc_count
    );
endinterface

`default_nettype wire

// File: rtl/aes_seq_ctrl.sv
// ============================================================================
// Module   : aes_seq_ctrl
// Brief    : Command sequencer for aes_core: key load / encrypt sequencing,
//            scope trigger window, encryption counter and hang watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_seq_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  wire            clk,
    input  wire            reset_n,
    aes_seq_ctrl_if.slave  bus
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KEY_GO    = 3'd1,
        S_KEY_GUARD = 3'd2,
        S_KEY_WAIT  = 3'd3,
        S_ENC_GO    = 3'd4,
        S_ENC_GUARD = 3'd5,
        S_ENC_WAIT  = 3'd6,
        S_RESP      = 3'd7
    } state_e;

    state_e           state_q;
    logic [255:0]     key_q;
    logic             keylen_q;
    logic [127:0]     block_q;
    logic [127:0]     rsp_data_q;
    logic             rsp_err_q;
    logic             trigger_q;
    logic             key_loaded_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WD_W-1:0]  wd_q;

    logic [WD_W-1:0]  wd_d;
    logic [CNT_W-1:0] cnt_d;
    logic             wd_expired;

    assign wd_d       = wd_q + WD_W'(1);
    assign cnt_d      = cnt_q + CNT_W'(1);
    // wd_q is 0 in the guard cycle, so reaching WD_LAST in a wait state means
    // TIMEOUT cycles have been spent across guard plus wait.
    assign wd_expired = (wd_q == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            keylen_q     <= 1'b0;
            block_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            trigger_q    <= 1'b0;
            key_loaded_q <= 1'b0;
            cnt_q        <= '0;
            wd_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (!bus.cmd_op) begin
                            key_q        <= bus.cmd_key;
                            keylen_q     <= bus.cmd_keylen;
                            key_loaded_q <= 1'b0;
                            state_q      <= S_KEY_GO;
                        end else if (key_loaded_q) begin
                            block_q   <= bus.cmd_block;
                            trigger_q <= 1'b1;
                            state_q   <= S_ENC_GO;
                        end else begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state_q    <= S_RESP;
                        end
                    end
                end
                S_KEY_GO: begin
                    wd_q    <= '0;
                    state_q <= S_KEY_GUARD;
                end
                S_KEY_GUARD: begin
                    wd_q    <= wd_d;
                    state_q <= S_KEY_WAIT;
                end
                S_KEY_WAIT: begin
                    wd_q <= wd_d;
                    if (bus.core_ready) begin
                        key_loaded_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (wd_expired) begin
                        key_loaded_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                S_ENC_GO: begin
                    wd_q    <= '0;
                    state_q <= S_ENC_GUARD;
                end
                S_ENC_GUARD: begin
                    wd_q    <= wd_d;
                    state_q <= S_ENC_WAIT;
                end
                S_ENC_WAIT: begin
                    wd_q <= wd_d;
                    if (bus.core_ready && bus.core_result_valid) begin
                        rsp_data_q <= bus.core_result;
                        rsp_err_q  <= 1'b0;
                        cnt_q      <= cnt_d;
                        trigger_q  <= 1'b0;
                        state_q    <= S_RESP;
                    end else if (wd_expired) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        trigger_q  <= 1'b0;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.core_init   = (state_q == S_KEY_GO);
    assign bus.core_next   = (state_q == S_ENC_GO);
    assign bus.rsp_valid   = (state_q == S_RESP);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.core_key    = key_q;
    assign bus.core_keylen = keylen_q;
    assign bus.core_block  = block_q;
    assign bus.trigger     = trigger_q;
    assign bus.key_loaded  = key_loaded_q;
    assign bus.enc_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_seq_ctrl.sv
// ============================================================================
// Module   : tb_aes_seq_ctrl
// Brief    : Directed self-checking bench for aes_seq_ctrl with a stub core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_seq_ctrl;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 20;

    localparam logic [255:0] FIPS_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    aes_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    aes_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Stub core: drops ready on a strobe, answers core_lat cycles later unless hung.
    int   core_lat  = 4;
    logic core_hang = 1'b0;
    int   busy_cnt;
    logic busy_enc;

    function automatic logic [127:0] core_model(input logic [255:0] k, input logic [127:0] b);
        if (k == FIPS_KEY && b == FIPS_PT) return FIPS_CT;
        return b ^ k[255:128];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.core_ready        <= 1'b1;
            bus.core_result_valid <= 1'b0;
            bus.core_result       <= '0;
            busy_cnt              <= 0;
            busy_enc              <= 1'b0;
        end else if (bus.core_init || bus.core_next) begin
            bus.core_ready        <= 1'b0;
            bus.core_result_valid <= 1'b0;
            busy_cnt              <= core_lat;
            busy_enc              <= bus.core_next;
        end else if (busy_cnt == 1) begin
            if (!core_hang) begin
                bus.core_ready        <= 1'b1;
                bus.core_result_valid <= busy_enc;
                bus.core_result       <= core_model(bus.core_key, bus.core_block);
                busy_cnt              <= 0;
            end
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Running totals of strobe-high cycles and trigger rising edges.
    int   n_init = 0;
    int   n_next = 0;
    int   n_trig = 0;
    logic trig_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.core_init) n_init++;
        if (bus.core_next) n_next++;
        if (bus.trigger && !trig_prev) n_trig++;
        trig_prev = bus.trigger;
    end

    task automatic send_cmd(input logic op, input logic kl, input logic [255:0] key, input logic [127:0] blk);
        int i;
        i = 0;
        while (!bus.cmd_ready && i < 50) begin @(negedge clk); i++; end
        n_total++;
        if (!bus.cmd_ready) $display("FAIL cmd_ready_wait: cmd_ready=%b, expected 1", bus.cmd_ready);
        else n_pass++;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_keylen = kl;
        bus.cmd_key    = key;
        bus.cmd_block  = blk;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int i;
        i = 0;
        while (!bus.rsp_valid && i < 200) begin @(negedge clk); i++; end
        n_total++;
        if (!bus.rsp_valid) $display("FAIL rsp_valid_wait: rsp_valid=%b, expected 1", bus.rsp_valid);
        else n_pass++;
    endtask

    task automatic ack_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic load_key(input logic kl, input logic [255:0] key);
        int i;
        send_cmd(1'b0, kl, key, '0);
        i = 0;
        while (!bus.key_loaded && i < 100) begin @(negedge clk); i++; end
        n_total++;
        if (bus.key_loaded !== 1'b1) $display("FAIL key_load_wait: key_loaded=%b, expected 1", bus.key_loaded);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_total++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b, expected 1", bus.cmd_ready);
        else n_pass++;
        n_total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.core_init, bus.core_next, bus.core_keylen,
             bus.trigger, bus.key_loaded} !== 7'b0)
            $display("FAIL reset_flags: got %b, expected 0000000", {bus.rsp_valid, bus.rsp_err,
                     bus.core_init, bus.core_next, bus.core_keylen, bus.trigger, bus.key_loaded});
        else n_pass++;
        n_total++;
        if (bus.rsp_data !== 128'h0 || bus.core_block !== 128'h0 || bus.core_key !== 256'h0)
            $display("FAIL reset_data: rsp_data=%h core_block=%h core_key=%h, expected all 0",
                     bus.rsp_data, bus.core_block, bus.core_key);
        else n_pass++;
        n_total++;
        if (bus.enc_count !== 2'd0) $display("FAIL reset_enc_count: got %0d, expected 0", bus.enc_count);
        else n_pass++;
    endtask

    task automatic test_no_key();
        int nx;
        nx = n_next;
        send_cmd(1'b1, 1'b0, '0, FIPS_PT);
        wait_rsp();
        n_total++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 128'h0)
            $display("FAIL nokey_rsp: err=%b data=%h, expected err=1 data=0", bus.rsp_err, bus.rsp_data);
        else n_pass++;
        ack_rsp();
        n_total++;
        if (n_next != nx) $display("FAIL nokey_next: core_next cycles=%0d, expected 0", n_next - nx);
        else n_pass++;
        n_total++;
        if (bus.enc_count !== 2'd0) $display("FAIL nokey_enc_count: got %0d, expected 0", bus.enc_count);
        else n_pass++;
    endtask

    task automatic test_key_encrypt();
        int ni, nx, nt;
        ni = n_init;
        load_key(1'b0, FIPS_KEY);
        n_total++;
        if (n_init - ni != 1) $display("FAIL key_init_width: core_init cycles=%0d, expected 1", n_init - ni);
        else n_pass++;
        n_total++;
        if (bus.core_key !== FIPS_KEY || bus.core_keylen !== 1'b0)
            $display("FAIL key_latch: core_key=%h keylen=%b, expected %h keylen=0",
                     bus.core_key, bus.core_keylen, FIPS_KEY);
        else n_pass++;
        nx = n_next;
        nt = n_trig;
        send_cmd(1'b1, 1'b0, '0, FIPS_PT);
        wait_rsp();
        n_total++;
        if (bus.rsp_data !== FIPS_CT || bus.rsp_err !== 1'b0)
            $display("FAIL fips_rsp: data=%h err=%b, expected %h err=0", bus.rsp_data, bus.rsp_err, FIPS_CT);
        else n_pass++;
        n_total++;
        if (bus.core_block !== FIPS_PT) $display("FAIL block_latch: got %h, expected %h", bus.core_block, FIPS_PT);
        else n_pass++;
        ack_rsp();
        n_total++;
        if (n_next - nx != 1) $display("FAIL enc_next_width: core_next cycles=%0d, expected 1", n_next - nx);
        else n_pass++;
        n_total++;
        if (bus.enc_count !== 2'd1 || bus.key_loaded !== 1'b1)
            $display("FAIL fips_state: enc_count=%0d key_loaded=%b, expected 1 and 1", bus.enc_count, bus.key_loaded);
        else n_pass++;
        n_total++;
        if (n_trig - nt != 1 || bus.trigger !== 1'b0)
            $display("FAIL fips_trigger: pulses=%0d trigger=%b, expected 1 and 0", n_trig - nt, bus.trigger);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [127:0] blk, d0;
        logic ok;
        int nx;
        blk = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        send_cmd(1'b1, 1'b0, '0, blk);
        wait_rsp();
        d0 = bus.rsp_data;
        n_total++;
        if (d0 !== (blk ^ FIPS_KEY[255:128])) $display("FAIL bp_data: got %h, expected %h", d0, blk ^ FIPS_KEY[255:128]);
        else n_pass++;
        nx = n_next;
        ok = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.cmd_ready !== 1'b0) ok = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        n_total++;
        if (!ok) $display("FAIL bp_hold: rsp_valid=%b data=%h cmd_ready=%b, expected 1, %h, 0",
                          bus.rsp_valid, bus.rsp_data, bus.cmd_ready, d0);
        else n_pass++;
        ack_rsp();
        n_total++;
        if (bus.rsp_valid !== 1'b0 || n_next != nx)
            $display("FAIL bp_single: rsp_valid=%b extra_next=%0d, expected 0 and 0", bus.rsp_valid, n_next - nx);
        else n_pass++;
        n_total++;
        if (bus.enc_count !== 2'd2) $display("FAIL bp_enc_count: got %0d, expected 2", bus.enc_count);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        int i, k;
        core_hang = 1'b1;
        send_cmd(1'b1, 1'b0, '0, FIPS_PT);
        i = 0;
        while (!bus.core_next && i < 20) begin @(negedge clk); i++; end
        n_total++;
        if (bus.trigger !== 1'b1) $display("FAIL wd_trigger_on: trigger=%b, expected 1", bus.trigger);
        else n_pass++;
        k = 0;
        while (!bus.rsp_valid && k < TIMEOUT + 20) begin @(negedge clk); k++; end
        n_total++;
        if (k != TIMEOUT + 1) $display("FAIL wd_latency: next-to-rsp cycles=%0d, expected %0d", k, TIMEOUT + 1);
        else n_pass++;
        n_total++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 128'h0 || bus.trigger !== 1'b0)
            $display("FAIL wd_rsp: err=%b data=%h trigger=%b, expected 1, 0, 0", bus.rsp_err, bus.rsp_data, bus.trigger);
        else n_pass++;
        ack_rsp();
        core_hang = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus.enc_count !== 2'd2) $display("FAIL wd_enc_count: got %0d, expected 2", bus.enc_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int i;
        send_cmd(1'b1, 1'b0, '0, FIPS_PT);
        i = 0;
        while (!bus.core_next && i < 20) begin @(negedge clk); i++; end
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (bus.cmd_ready !== 1'b1 || bus.trigger !== 1'b0 || bus.key_loaded !== 1'b0 ||
            bus.rsp_valid !== 1'b0 || bus.enc_count !== 2'd0 || bus.core_block !== 128'h0 ||
            bus.core_key !== 256'h0)
            $display("FAIL midreset_async: cmd_ready=%b trigger=%b key_loaded=%b rsp_valid=%b enc_count=%0d, expected 1,0,0,0,0 with latches cleared",
                     bus.cmd_ready, bus.trigger, bus.key_loaded, bus.rsp_valid, bus.enc_count);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_cmd(1'b1, 1'b0, '0, FIPS_PT);
        wait_rsp();
        n_total++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 128'h0)
            $display("FAIL midreset_nokey: err=%b data=%h, expected err=1 data=0", bus.rsp_err, bus.rsp_data);
        else n_pass++;
        ack_rsp();
    endtask

    task automatic test_wrap();
        int seq [5] = '{1, 2, 3, 0, 1};
        logic [127:0] blk;
        int nt;
        load_key(1'b1, KEY256);
        n_total++;
        if (bus.core_keylen !== 1'b1) $display("FAIL wrap_keylen: got %b, expected 1", bus.core_keylen);
        else n_pass++;
        for (int e = 0; e < 5; e++) begin
            blk = {4{32'h1000_0000 + 32'(e)}};
            nt  = n_trig;
            send_cmd(1'b1, 1'b0, '0, blk);
            wait_rsp();
            n_total++;
            if (bus.rsp_data !== (blk ^ KEY256[255:128]) || bus.rsp_err !== 1'b0)
                $display("FAIL wrap_data%0d: data=%h err=%b, expected %h err=0", e, bus.rsp_data, bus.rsp_err,
                         blk ^ KEY256[255:128]);
            else n_pass++;
            ack_rsp();
            n_total++;
            if (bus.enc_count !== 2'(seq[e]) || n_trig - nt != 1)
                $display("FAIL wrap_count%0d: enc_count=%0d pulses=%0d, expected %0d and 1", e, bus.enc_count,
                         n_trig - nt, seq[e]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 1'b0;
        bus.cmd_keylen = 1'b0;
        bus.cmd_key    = '0;
        bus.cmd_block  = '0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_no_key();
        test_key_encrypt();
        test_back_pressure();
        test_watchdog();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
